// File: rtl/button_event_scheduler.sv
// button_event_scheduler: latches button presses, round-robin arbitrates them, queues ids in a FWFT FIFO
module button_event_scheduler #(
  parameter int N_BUTTONS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W = $clog2(N_BUTTONS),
  localparam int PW   = $clog2(FIFO_DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] press,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [ID_W-1:0]      evt_id,
  output logic [N_BUTTONS-1:0] pending,
  output logic [LW-1:0]        fifo_level,
  output logic                 overflow,
  input  logic                 clr_overflow
);
  localparam logic [ID_W:0] NB = (ID_W+1)'(N_BUTTONS);
  logic [N_BUTTONS-1:0] pending_q, pending_d, grant;
  logic [ID_W-1:0]      rr_q, rr_d, gnt_id;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d, found, push, pop, can_push;
  logic [ID_W:0]        sum;
  logic [ID_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ID_W-1:0]      mem_d [FIFO_DEPTH];
  assign evt_valid  = level_q != '0;
  assign evt_id     = mem_q[rd_q];
  assign pending    = pending_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign can_push   = level_q != LW'(FIFO_DEPTH);
  assign pop        = evt_valid & evt_ready;
  // Round-robin scan of registered pending bits starting at rr_q; grant only if FIFO has room
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    sum    = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(k);
      sum = (sum >= NB) ? sum - NB : sum;
      if (!found && can_push && pending_q[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        gnt_id = sum[ID_W-1:0];
      end
    end
  end
  // Next-state: request capture, overflow, pointer and level updates, FIFO write
  always_comb begin
    push       = found;
    grant      = found ? N_BUTTONS'(1) << gnt_id : '0;
    pending_d  = (pending_q & ~grant) | press;
    overflow_d = (|(press & pending_q & ~grant)) | (overflow_q & ~clr_overflow);
    rr_d       = !found ? rr_q : (gnt_id == ID_W'(N_BUTTONS-1)) ? '0 : gnt_id + 1'b1;
    wr_d       = wr_q + PW'(push);
    rd_d       = rd_q + PW'(pop);
    level_d    = level_q + LW'(push) - LW'(pop);
    mem_d      = mem_q;
    if (push) mem_d[wr_q] = gnt_id;
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler: directed checks of capture, round-robin, FIFO backpressure and overflow
module tb_button_event_scheduler;
  logic       clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b0, clr_overflow = 1'b0;
  logic [3:0] press = '0, pending;
  logic       evt_valid, overflow;
  logic [1:0] evt_id;
  logic [2:0] fifo_level;
  int         tests = 0, fails = 0;
  button_event_scheduler #(.N_BUTTONS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .pending(pending), .fifo_level(fifo_level), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    // single press of button 2 with consumer ready
    press = 4'b0100; evt_ready = 1'b1;
    tick();
    press = '0;
    chk("single_pending", 32'(pending), 4'b0100);
    chk("single_valid_early", 32'(evt_valid), 0);
    tick();
    chk("single_valid", 32'(evt_valid), 1);
    chk("single_id", 32'(evt_id), 2);
    chk("single_level1", 32'(fifo_level), 1);
    tick();
    chk("single_level0", 32'(fifo_level), 0);
    chk("single_drained", 32'(evt_valid), 0);
    // build state, then reset mid-cycle without a clock edge
    evt_ready = 1'b0; press = 4'b0011;
    tick();
    press = '0;
    tick();
    chk("pre_rst_level", 32'(fifo_level), 1);
    chk("pre_rst_pending", 32'(pending), 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt_valid), 0);
    chk("async_rst_pending", 32'(pending), 0);
    chk("async_rst_level", 32'(fifo_level), 0);
    chk("async_rst_ovf", 32'(overflow), 0);
    chk("async_rst_id", 32'(evt_id), 0);
    tick();
    rst_n = 1'b1;
    // round robin with all four buttons
    press = 4'b1111;
    tick();
    press = '0;
    repeat (4) tick();
    chk("rr_level", 32'(fifo_level), 4);
    chk("rr_pending", 32'(pending), 0);
    chk("rr_id0", 32'(evt_id), 0);
    evt_ready = 1'b1;
    tick();
    chk("rr_id1", 32'(evt_id), 1);
    tick();
    chk("rr_id2", 32'(evt_id), 2);
    tick();
    chk("rr_id3", 32'(evt_id), 3);
    tick();
    chk("rr_empty", 32'(evt_valid), 0);
    evt_ready = 1'b0;
    // rr pointer back at 0: order 0 then 3
    press = 4'b1001;
    tick();
    press = '0;
    tick();
    tick();
    chk("rr2_level", 32'(fifo_level), 2);
    chk("rr2_id0", 32'(evt_id), 0);
    evt_ready = 1'b1;
    tick();
    chk("rr2_id3", 32'(evt_id), 3);
    tick();
    chk("rr2_empty", 32'(evt_valid), 0);
    evt_ready = 1'b0;
    // fill FIFO, then two extra presses of button 0 three cycles apart
    press = 4'b1111;
    tick();
    press = '0;
    repeat (4) tick();
    chk("full_level", 32'(fifo_level), 4);
    press = 4'b0001;
    tick();
    press = '0;
    chk("full_pending", 32'(pending), 4'b0001);
    chk("full_ovf0", 32'(overflow), 0);
    tick();
    tick();
    press = 4'b0001;
    tick();
    press = '0;
    chk("full_ovf1", 32'(overflow), 1);
    chk("full_pending2", 32'(pending), 4'b0001);
    chk("full_head", 32'(evt_id), 0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("pop_level", 32'(fifo_level), 3);
    chk("pop_pending_held", 32'(pending), 4'b0001);
    tick();
    chk("refill_level", 32'(fifo_level), 4);
    chk("refill_pending", 32'(pending), 0);
    chk("bp_id1", 32'(evt_id), 1);
    evt_ready = 1'b1;
    tick();
    chk("bp_id2", 32'(evt_id), 2);
    tick();
    chk("bp_id3", 32'(evt_id), 3);
    tick();
    chk("bp_id0", 32'(evt_id), 0);
    tick();
    chk("bp_empty", 32'(evt_valid), 0);
    evt_ready = 1'b0;
    // overflow clear alone
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_alone", 32'(overflow), 0);
    // clear coinciding with a dropped press: set wins
    press = 4'b1111;
    tick();
    press = '0;
    repeat (4) tick();
    press = 4'b0010;
    tick();
    clr_overflow = 1'b1;
    tick();
    press = '0;
    chk("clr_vs_set", 32'(overflow), 1);
    tick();
    clr_overflow = 1'b0;
    chk("clr_after", 32'(overflow), 0);
    evt_ready = 1'b1;
    repeat (8) tick();
    evt_ready = 1'b0;
    chk("drain_level", 32'(fifo_level), 0);
    chk("drain_pending", 32'(pending), 0);
    // press[1] again in the cycle it is granted
    press = 4'b0010;
    tick();
    tick();
    press = '0;
    chk("simul_pending", 32'(pending), 4'b0010);
    chk("simul_ovf", 32'(overflow), 0);
    chk("simul_level1", 32'(fifo_level), 1);
    tick();
    chk("simul_level2", 32'(fifo_level), 2);
    chk("simul_id_a", 32'(evt_id), 1);
    evt_ready = 1'b1;
    tick();
    chk("simul_id_b", 32'(evt_id), 1);
    tick();
    chk("simul_empty", 32'(evt_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
